decode_issue_arbiter: RTL and testbench

DECODE_ISSUE_ARBITER -- requirements
Module: decode_issue_arbiter

---
 rtl/decode_issue_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_decode_issue_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_arbiter.sv
// Two-thread round-robin issue arbiter in front of a credited decoder.
// Ports: per-thread valid/payload in, ready out; registered issue payload,
// enable, major ID, credit count and sticky credit overflow flag out.
module decode_issue_arbiter #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int creditDepth             = 4
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               t0Valid_i,
  input  logic                               t1Valid_i,
  input  logic [instructionWidth-1:0]        t0Instruction_i,
  input  logic [instructionWidth-1:0]        t1Instruction_i,
  input  logic [addressWidth-1:0]            t0Address_i,
  input  logic [addressWidth-1:0]            t1Address_i,
  input  logic                               t0Is64Bit_i,
  input  logic                               t1Is64Bit_i,
  input  logic [PidSize-1:0]                 t0Pid_i,
  input  logic [PidSize-1:0]                 t1Pid_i,
  input  logic [TidSize-1:0]                 t0Tid_i,
  input  logic [TidSize-1:0]                 t1Tid_i,
  output logic                               t0Ready_o,
  output logic                               t1Ready_o,
  input  logic                               stall_i,
  input  logic                               flush_i,
  input  logic                               creditReturn_i,
  output logic                               enable_o,
  output logic [instructionWidth-1:0]        instruction_o,
  output logic [addressWidth-1:0]            address_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 pid_o,
  output logic [TidSize-1:0]                 tid_o,
  output logic [instructionCounterWidth-1:0] majId_o,
  output logic [2:0]                         credits_o,
  output logic                               creditError_o
);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam logic [2:0] Depth = 3'(creditDepth);

  typedef logic [instructionCounterWidth-1:0] maj_t;

  state_e                      state_q, state_d;
  logic [2:0]                  credits_q, credits_d;
  logic                        err_q, err_d;
  logic                        last_q, last_d;
  maj_t                        cnt_q, cnt_d;
  logic                        en_q, en_d;
  maj_t                        maj_q, maj_d;
  logic [instructionWidth-1:0] ins_q, ins_d;
  logic [addressWidth-1:0]     adr_q, adr_d;
  logic                        b64_q, b64_d;
  logic [PidSize-1:0]          pid_q, pid_d;
  logic [TidSize-1:0]          tid_q, tid_d;

  logic grantable;
  logic pick1;
  logic grant0;
  logic grant1;
  logic grant;

  // last_q=1 means thread 1 won the previous grant.
  always_comb begin
    grantable = (state_q == RUN) &&
                !stall_i &&
                !flush_i &&
                (credits_q != 3'd0) &&
                !reset_i;
    pick1  = t1Valid_i &&
             (!t0Valid_i || !last_q);
    grant1 = grantable && pick1;
    grant0 = grantable && t0Valid_i && !pick1;
    grant  = grant0 | grant1;
  end

  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (grant && !creditReturn_i) begin
      credits_d = credits_q - 3'd1;
    end else if (!grant && creditReturn_i) begin
      // A return with every credit already home is dropped and flagged.
      if (credits_q == Depth) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + 3'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (credits_d == Depth) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    en_d   = grant;
    maj_d  = maj_q;
    ins_d  = ins_q;
    adr_d  = adr_q;
    b64_d  = b64_q;
    pid_d  = pid_q;
    tid_d  = tid_q;
    if (grant) begin
      last_d = grant1;
      maj_d  = cnt_q;
      cnt_d  = cnt_q + maj_t'(1);
      unique case (1'b1)
        grant1: begin
          ins_d = t1Instruction_i;
          adr_d = t1Address_i;
          b64_d = t1Is64Bit_i;
          pid_d = t1Pid_i;
          tid_d = t1Tid_i;
        end
        default: begin
          ins_d = t0Instruction_i;
          adr_d = t0Address_i;
          b64_d = t0Is64Bit_i;
          pid_d = t0Pid_i;
          tid_d = t0Tid_i;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= RUN;
      credits_q <= Depth;
      err_q     <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      maj_q     <= '0;
      ins_q     <= '0;
      adr_q     <= '0;
      b64_q     <= 1'b0;
      pid_q     <= '0;
      tid_q     <= '0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      err_q     <= err_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      maj_q     <= maj_d;
      ins_q     <= ins_d;
      adr_q     <= adr_d;
      b64_q     <= b64_d;
      pid_q     <= pid_d;
      tid_q     <= tid_d;
    end
  end

  assign t0Ready_o     = grant0;
  assign t1Ready_o     = grant1;
  assign enable_o      = en_q;
  assign instruction_o = ins_q;
  assign address_o     = adr_q;
  assign is64Bit_o     = b64_q;
  assign pid_o         = pid_q;
  assign tid_o         = tid_q;
  assign majId_o       = maj_q;
  assign credits_o     = credits_q;
  assign creditError_o = err_q;

endmodule

// File: tb/tb_decode_issue_arbiter.sv
// Bench for decode_issue_arbiter: vector table plus payload scoreboard.
// Built with a 4-bit major counter so the wrap case is short.
module tb_decode_issue_arbiter;

  logic        clock_i;
  logic        reset_i;
  logic        t0Valid_i, t1Valid_i;
  logic [31:0] t0Instruction_i, t1Instruction_i;
  logic [63:0] t0Address_i, t1Address_i;
  logic        t0Is64Bit_i, t1Is64Bit_i;
  logic [19:0] t0Pid_i, t1Pid_i;
  logic [15:0] t0Tid_i, t1Tid_i;
  logic        t0Ready_o, t1Ready_o;
  logic        stall_i, flush_i, creditReturn_i;
  logic        enable_o;
  logic [31:0] instruction_o;
  logic [63:0] address_o;
  logic        is64Bit_o;
  logic [19:0] pid_o;
  logic [15:0] tid_o;
  logic [3:0]  majId_o;
  logic [2:0]  credits_o;
  logic        creditError_o;

  decode_issue_arbiter #(
    .addressWidth(64),
    .instructionWidth(32),
    .PidSize(20),
    .TidSize(16),
    .instructionCounterWidth(4),
    .creditDepth(4)
  ) dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .t0Valid_i(t0Valid_i),
    .t1Valid_i(t1Valid_i),
    .t0Instruction_i(t0Instruction_i),
    .t1Instruction_i(t1Instruction_i),
    .t0Address_i(t0Address_i),
    .t1Address_i(t1Address_i),
    .t0Is64Bit_i(t0Is64Bit_i),
    .t1Is64Bit_i(t1Is64Bit_i),
    .t0Pid_i(t0Pid_i),
    .t1Pid_i(t1Pid_i),
    .t0Tid_i(t0Tid_i),
    .t1Tid_i(t1Tid_i),
    .t0Ready_o(t0Ready_o),
    .t1Ready_o(t1Ready_o),
    .stall_i(stall_i),
    .flush_i(flush_i),
    .creditReturn_i(creditReturn_i),
    .enable_o(enable_o),
    .instruction_o(instruction_o),
    .address_o(address_o),
    .is64Bit_o(is64Bit_o),
    .pid_o(pid_o),
    .tid_o(tid_o),
    .majId_o(majId_o),
    .credits_o(credits_o),
    .creditError_o(creditError_o)
  );

  typedef struct {
    bit rst, t0v, t1v, stall, flush, ret;
    bit r0, r1;
    int cred;
    bit err;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] adr;
    logic        b64;
    logic [19:0] pid;
    logic [15:0] tid;
    logic [3:0]  maj;
  } pay_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] exp_maj = '0;
  pay_t hold;
  pay_t sb[$];
  vec_t tbl[$];

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  function automatic vec_t v(
    bit rst, bit t0v, bit t1v, bit stall, bit flush, bit ret,
    bit r0, bit r1, int cred, bit err);
    vec_t x;
    x.rst = rst; x.t0v = t0v; x.t1v = t1v;
    x.stall = stall; x.flush = flush; x.ret = ret;
    x.r0 = r0; x.r1 = r1; x.cred = cred; x.err = err;
    return x;
  endfunction

  task automatic chk(input string n,
                     input logic [63:0] a,
                     input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic step(input vec_t x);
    pay_t p0, p1, e;
    p0.ins = $urandom;
    p0.adr = {$urandom, $urandom};
    p0.b64 = 1'($urandom_range(0, 1));
    p0.pid = 20'($urandom);
    p0.tid = 16'($urandom);
    p0.maj = '0;
    p1.ins = $urandom;
    p1.adr = {$urandom, $urandom};
    p1.b64 = 1'($urandom_range(0, 1));
    p1.pid = 20'($urandom);
    p1.tid = 16'($urandom);
    p1.maj = '0;
    reset_i         = x.rst;
    t0Valid_i       = x.t0v;
    t1Valid_i       = x.t1v;
    stall_i         = x.stall;
    flush_i         = x.flush;
    creditReturn_i  = x.ret;
    t0Instruction_i = p0.ins;
    t0Address_i     = p0.adr;
    t0Is64Bit_i     = p0.b64;
    t0Pid_i         = p0.pid;
    t0Tid_i         = p0.tid;
    t1Instruction_i = p1.ins;
    t1Address_i     = p1.adr;
    t1Is64Bit_i     = p1.b64;
    t1Pid_i         = p1.pid;
    t1Tid_i         = p1.tid;
    #1;
    chk("t0Ready", 64'(t0Ready_o), 64'(x.r0));
    chk("t1Ready", 64'(t1Ready_o), 64'(x.r1));
    if (x.r0 || x.r1) begin
      e = x.r0 ? p0 : p1;
      e.maj = exp_maj;
      exp_maj = exp_maj + 4'd1;
      sb.push_back(e);
    end
    @(posedge clock_i);
    #1;
    if (x.rst) begin
      exp_maj = '0;
      hold = '{default: '0};
      sb.delete();
    end
    chk("enable", 64'(enable_o), 64'(x.r0 | x.r1));
    if ((x.r0 || x.r1) && sb.size() > 0) begin
      hold = sb.pop_front();
    end
    chk("instruction", 64'(instruction_o), 64'(hold.ins));
    chk("address", address_o, hold.adr);
    chk("is64Bit", 64'(is64Bit_o), 64'(hold.b64));
    chk("pid", 64'(pid_o), 64'(hold.pid));
    chk("tid", 64'(tid_o), 64'(hold.tid));
    chk("majId", 64'(majId_o), 64'(hold.maj));
    chk("credits", 64'(credits_o), 64'(x.cred));
    chk("creditError", 64'(creditError_o), 64'(x.err));
  endtask

  initial begin
    reset_i = 1'b0;
    t0Valid_i = 1'b0;
    t1Valid_i = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    creditReturn_i = 1'b0;
    t0Instruction_i = '0;
    t1Instruction_i = '0;
    t0Address_i = '0;
    t1Address_i = '0;
    t0Is64Bit_i = 1'b0;
    t1Is64Bit_i = 1'b0;
    t0Pid_i = '0;
    t1Pid_i = '0;
    t0Tid_i = '0;
    t1Tid_i = '0;
    hold = '{default: '0};

    // rst t0v t1v stall flush ret | r0 r1 cred err
    tbl.push_back(v(1,1,1,0,0,0, 0,0, 4,0));
    tbl.push_back(v(0,1,1,0,0,0, 1,0, 3,0));
    tbl.push_back(v(0,1,1,0,0,0, 0,1, 2,0));
    tbl.push_back(v(0,1,1,0,0,0, 1,0, 1,0));
    tbl.push_back(v(0,1,1,0,0,0, 0,1, 0,0));
    tbl.push_back(v(0,1,1,0,0,0, 0,0, 0,0));
    tbl.push_back(v(0,1,1,0,0,1, 0,0, 1,0));
    tbl.push_back(v(0,1,1,0,0,0, 1,0, 0,0));
    tbl.push_back(v(0,1,1,0,0,1, 0,0, 1,0));
    tbl.push_back(v(0,1,1,0,0,1, 0,1, 1,0));
    tbl.push_back(v(0,0,0,0,0,1, 0,0, 2,0));
    tbl.push_back(v(0,0,0,0,0,1, 0,0, 3,0));
    tbl.push_back(v(0,0,0,0,0,1, 0,0, 4,0));
    tbl.push_back(v(0,0,0,0,0,1, 0,0, 4,1));
    tbl.push_back(v(0,1,1,0,1,0, 0,0, 4,1));
    tbl.push_back(v(0,1,1,0,0,0, 0,0, 4,1));
    tbl.push_back(v(0,1,1,0,0,0, 1,0, 3,1));
    tbl.push_back(v(0,0,0,0,0,1, 0,0, 4,1));
    tbl.push_back(v(1,1,1,1,1,1, 0,0, 4,0));
    tbl.push_back(v(0,1,1,0,0,0, 1,0, 3,0));
    tbl.push_back(v(0,1,1,0,0,0, 0,1, 2,0));
    tbl.push_back(v(0,1,1,0,1,0, 0,0, 2,0));
    tbl.push_back(v(0,1,1,0,0,1, 0,0, 3,0));
    tbl.push_back(v(0,1,1,0,0,0, 0,0, 3,0));
    tbl.push_back(v(0,1,1,0,0,1, 0,0, 4,0));
    tbl.push_back(v(0,1,1,0,0,0, 1,0, 3,0));
    tbl.push_back(v(0,0,1,0,0,0, 0,1, 2,0));
    tbl.push_back(v(0,0,1,0,0,0, 0,1, 1,0));
    tbl.push_back(v(0,0,1,1,0,1, 0,0, 2,0));
    tbl.push_back(v(0,0,1,0,0,0, 0,1, 1,0));
    tbl.push_back(v(0,1,0,0,0,0, 1,0, 0,0));
    tbl.push_back(v(0,1,1,0,0,0, 0,0, 0,0));

    @(posedge clock_i);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
    end

    // Major counter wrap: 17 issues from reset, returns keep credits at 3.
    step(v(1,0,0,0,0,0, 0,0, 4,0));
    for (int i = 0; i < 17; i++) begin
      step(v(0,1,0,0,0,(i > 0), 1,0, 3,0));
      if (i == 15) chk("majId_16th", 64'(majId_o), 64'd15);
      if (i == 16) chk("majId_17th", 64'(majId_o), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
